// File: rtl/price_frame_parser_pkg.sv
// Shared constants, widths and FSM state encoding for the price frame parser
// and anything that consumes or checks its frames.
package price_frame_parser_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam logic [7:0] FOOTER_BYTE = 8'h55;
  localparam int         PRICE_W     = 16;
  localparam int         FRAME_W     = 16;
  localparam int         ERR_W       = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A_HI = 3'd1,
    A_LO = 3'd2,
    B_HI = 3'd3,
    B_LO = 3'd4,
    FOOT = 3'd5
  } parser_state_t;

  function automatic logic [PRICE_W-1:0] join_price(input logic [7:0] hi,
                                                     input logic [7:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
    return (value == {ERR_W{1'b1}}) ? value : value + ERR_W'(1);
  endfunction

endpackage

// File: rtl/price_frame_parser_byte_gap_timer.sv
// Inter-byte gap watchdog: counts enabled cycles since the last clear and
// pulses expire on the cycle whose edge would complete GAP_CYCLES of silence.
module byte_gap_timer #(
  parameter int GAP_CYCLES = 104_167
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [CNT_W-1:0] count;
  logic             at_limit;

  // A clear in the same cycle wins, so a byte arriving exactly at the limit
  // is treated as on time.
  assign at_limit = (count == CNT_W'(GAP_CYCLES - 1));
  assign expire   = enable && !clear && at_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || !enable || at_limit) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/price_frame_parser.sv
// Parses HEADER, A_hi, A_lo, B_hi, B_lo, FOOTER byte frames into two
// registered prices, with footer checking, gap timeout and frame statistics.
module price_frame_parser
  import price_frame_parser_pkg::*;
#(
  parameter logic [7:0] HEADER     = HEADER_BYTE,
  parameter logic [7:0] FOOTER     = FOOTER_BYTE,
  parameter int         GAP_CYCLES = 104_167
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [PRICE_W-1:0] price_a,
  output logic [PRICE_W-1:0] price_b,
  output logic               prices_valid,
  output logic               frame_error,
  output logic [FRAME_W-1:0] frame_count,
  output logic [ERR_W-1:0]   error_count
);

  parser_state_t state;
  parser_state_t next_state;

  logic       gap_expire;
  logic       timer_enable;
  logic       accept;
  logic       abort;
  logic [7:0] shadow_a_hi;
  logic [7:0] shadow_a_lo;
  logic [7:0] shadow_b_hi;
  logic [7:0] shadow_b_lo;

  assign timer_enable = (state != IDLE);

  byte_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (rx_valid),
    .enable(timer_enable),
    .expire(gap_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Data bytes are never compared against HEADER/FOOTER; only the byte in
  // the FOOT slot decides accept versus abort (with header resync).
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    abort      = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: if (rx_data == HEADER) next_state = A_HI;
        A_HI: next_state = A_LO;
        A_LO: next_state = B_HI;
        B_HI: next_state = B_LO;
        B_LO: next_state = FOOT;
        FOOT: begin
          if (rx_data == FOOTER) begin
            accept     = 1'b1;
            next_state = IDLE;
          end else begin
            abort      = 1'b1;
            next_state = (rx_data == HEADER) ? A_HI : IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end else if (gap_expire) begin
      abort      = 1'b1;
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_a_hi <= '0;
      shadow_a_lo <= '0;
      shadow_b_hi <= '0;
      shadow_b_lo <= '0;
    end else if (rx_valid) begin
      case (state)
        A_HI:    shadow_a_hi <= rx_data;
        A_LO:    shadow_a_lo <= rx_data;
        B_HI:    shadow_b_hi <= rx_data;
        B_LO:    shadow_b_lo <= rx_data;
        default: ;
      endcase
    end else if (gap_expire) begin
      shadow_a_hi <= '0;
      shadow_a_lo <= '0;
      shadow_b_hi <= '0;
      shadow_b_lo <= '0;
    end
  end

  // Prices only move on an accepted footer, so a partial frame never leaks out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      price_a      <= '0;
      price_b      <= '0;
      prices_valid <= 1'b0;
      frame_error  <= 1'b0;
      frame_count  <= '0;
      error_count  <= '0;
    end else begin
      prices_valid <= accept;
      frame_error  <= abort;
      if (accept) begin
        price_a     <= join_price(shadow_a_hi, shadow_a_lo);
        price_b     <= join_price(shadow_b_hi, shadow_b_lo);
        frame_count <= frame_count + FRAME_W'(1);
      end
      if (abort) begin
        error_count <= sat_inc(error_count);
      end
    end
  end

  pulses_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(prices_valid && frame_error));

endmodule

// File: doc/price_frame_parser.md
PRICE_FRAME_PARSER -- requirements
Module: price_frame_parser

Interface
REQ-001 Parameter: HEADER, 8'hAA, frame start byte.
REQ-002 Parameter: FOOTER, 8'h55, frame end byte.
REQ-003 Parameter: GAP_CYCLES, 104_167, max clk cycles between consecutive bytes of one frame (about 2 ms at 50 MHz).
REQ-004 Port: clk  input  1  50 MHz system clock, rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: rx_data  input  8  received byte from UART receiver.
REQ-007 Port: rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-008 Port: price_a  output  16  last accepted exchange A price, integer cents.
REQ-009 Port: price_b  output  16  last accepted exchange B price, integer cents.
REQ-010 Port: prices_valid  output  1  one-cycle pulse when price_a/price_b update.
REQ-011 Port: frame_error  output  1  one-cycle pulse on aborted frame.
REQ-012 Port: frame_count  output  16  accepted frames, wraps 0xFFFF->0.
REQ-013 Port: error_count  output  8  aborted frames, saturates at 0xFF.

Function
REQ-014 Frame format: HEADER, A_hi, A_lo, B_hi, B_lo, FOOTER; prices big-endian unsigned 16-bit.
REQ-015 FSM states: IDLE, A_HI, A_LO, B_HI, B_LO, FOOT; transitions happen only on rx_valid, except timeout.
REQ-016 IDLE: byte == HEADER -> A_HI; any other byte ignored, no error.
REQ-017 A_HI..B_LO: store byte in shadow register, advance to the next state; data bytes may take any value, including 0xAA and 0x55.
REQ-018 FOOT, byte == FOOTER: copy shadows to price_a/price_b, pulse prices_valid, increment frame_count, go to IDLE.
REQ-019 Footer update timing: outputs change and prices_valid is high in the cycle after the footer rx_valid (1-cycle latency).
REQ-020 FOOT, byte != FOOTER: pulse frame_error, increment error_count, leave outputs unchanged.
REQ-021 Next state after footer mismatch: A_HI if the byte == HEADER (resync), otherwise IDLE.
REQ-022 Gap timer: cleared on every rx_valid; counts while state != IDLE; held at 0 in IDLE.
REQ-023 Timer reaches GAP_CYCLES: pulse frame_error, increment error_count, discard shadows, go to IDLE.
REQ-024 Timeout and rx_valid in the same cycle: the byte is processed and no timeout occurs.
REQ-025 prices_valid and frame_error are never high in the same cycle.
REQ-026 price_a/price_b hold their values between accepted frames; shadows never reach the outputs mid-frame.

Reset
REQ-027 rst low: state IDLE; price_a, price_b, frame_count, error_count, gap timer, and shadows all 0; prices_valid and frame_error 0.
REQ-028 Reset takes effect immediately, including mid-frame; a partial frame is discarded silently without an error count.
REQ-029 After rst rises, the first byte accepted is the next rx_valid at a rising clk edge.

Structure
REQ-030 Shared package holds HEADER/FOOTER constants, PRICE_W=16, and the FSM state typedef/encoding, so arbitrage_engine and the test bench share them.
REQ-031 One sub-module, byte_gap_timer (clear, enable, expire pulse, parameter GAP_CYCLES), is instantiated once; all other logic is inline.

Verification
REQ-032 Bytes AA 10 AE 10 8B 55 -> price_a=0x10AE (4270), price_b=0x108B (4235), one prices_valid pulse, frame_count=1.
REQ-033 Bytes AA 10 AE 10 8B 00 -> one frame_error pulse, error_count=1, prices unchanged, no prices_valid pulse.
REQ-034 Bytes 12 34 55 followed by a good frame -> no frame_error, frame accepted, frame_count incremented.
REQ-035 Bytes AA 10 AE then 150_000 idle cycles -> frame_error exactly GAP_CYCLES cycles after the 0xAE strobe; a following good frame is accepted.
REQ-036 Bytes AA 10 AE 10 8B AA 11 22 33 44 55 -> frame_error on the sixth byte, then price_a=0x1122, price_b=0x3344 accepted.
REQ-037 rst pulled low after AA 10 -> all outputs 0; after release, a good frame is accepted and error_count=0.
